// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: the per-stage entry
// record, the bubble value, the register-file forwarding code and clog2.
package hazard_pkg;

  localparam int HZ_REG_W  = 5;
  localparam int HZ_TNEW_W = 2;

  // One in-flight instruction: destination, cycles until its result exists,
  // and whether it started a mult/div operation.
  typedef struct packed {
    logic [HZ_REG_W-1:0]  dst;
    logic [HZ_TNEW_W-1:0] tnew;
    logic                 md;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  // Forwarding select code meaning "no bypass, use the normal operand path".
  localparam int FWD_RF = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode inputs and hazard outputs of the scoreboard, bundled so the
// decoder drives one port and the scoreboard consumes it.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_W    = HZ_REG_W,
  parameter int TNEW_W   = HZ_TNEW_W,
  parameter int STAGES   = 3,
  parameter int RD_PORTS = 2,
  parameter int FS_W     = clog2(STAGES + 1)
);

  logic                         d_valid;
  logic [REG_W-1:0]             d_dst;
  logic [TNEW_W-1:0]            d_tnew;
  logic [RD_PORTS*REG_W-1:0]    d_src;
  logic [RD_PORTS-1:0]          d_src_used;
  logic [RD_PORTS*TNEW_W-1:0]   d_tuse;
  logic                         d_md_start;
  logic                         d_md_use;
  logic                         clear;
  logic                         stall;
  logic [RD_PORTS*FS_W-1:0]     fwd_d;
  logic [RD_PORTS*FS_W-1:0]     fwd_e;
  logic                         md_busy;

  modport master (
    output d_valid, d_dst, d_tnew, d_src, d_src_used, d_tuse,
           d_md_start, d_md_use, clear,
    input  stall, fwd_d, fwd_e, md_busy
  );

  modport slave (
    input  d_valid, d_dst, d_tnew, d_src, d_src_used, d_tuse,
           d_md_start, d_md_use, clear,
    output stall, fwd_d, fwd_e, md_busy
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority encoder: finds the lowest-numbered scoreboard entry
// at or after FIRST whose destination equals the source register.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_W  = HZ_REG_W,
  parameter int TNEW_W = HZ_TNEW_W,
  parameter int STAGES = 3,
  parameter int FIRST  = 0,
  parameter int FS_W   = clog2(STAGES + 1)
) (
  input  logic [REG_W-1:0]  src,
  input  logic              used,
  input  entry_t            entries [STAGES],
  output logic              hit,
  output logic [FS_W-1:0]   stage,
  output logic [TNEW_W-1:0] tnew
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit   = 1'b0;
    stage = '0;
    tnew  = '0;
    for (int k = STAGES - 1; k >= FIRST; k--) begin
      if (used && (src != '0) && (entries[k].dst == src)) begin
        hit   = 1'b1;
        stage = FS_W'(k + 1);
        tnew  = entries[k].tnew;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Registered hazard scoreboard: tracks dst/Tnew of instructions in E..W,
// produces the D stall, D/E forwarding selects and the mult/div interlock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W    = HZ_REG_W,
  parameter int TNEW_W   = HZ_TNEW_W,
  parameter int STAGES   = 3,
  parameter int RD_PORTS = 2,
  parameter int MD_LAT   = 5,
  parameter int FS_W     = clog2(STAGES + 1)
) (
  input logic                clk,
  input logic                reset_n,
  hazard_scoreboard_if.slave hif
);

  localparam int MDC_W = clog2(MD_LAT + 1);

  entry_t                    ent_q [STAGES];
  entry_t                    ent_d [STAGES];
  logic [RD_PORTS*REG_W-1:0] e_src_q, e_src_d;
  logic [RD_PORTS-1:0]       e_used_q, e_used_d;
  logic [MDC_W-1:0]          md_cnt_q, md_cnt_d;

  logic [RD_PORTS-1:0]       d_hit, e_hit, late;
  logic [FS_W-1:0]           d_stage [RD_PORTS];
  logic [FS_W-1:0]           e_stage [RD_PORTS];
  logic [TNEW_W-1:0]         d_tnew_m [RD_PORTS];
  logic [TNEW_W-1:0]         e_tnew_m [RD_PORTS];
  logic                      stall, accept, md_busy;

  // Per source port: one matcher for the D consumer (all stages) and one for
  // the E consumer (M onwards, since E itself is the consumer's own slot).
  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_port
      hazard_match #(
        .REG_W(REG_W), .TNEW_W(TNEW_W), .STAGES(STAGES), .FIRST(0), .FS_W(FS_W)
      ) u_match_d (
        .src     (hif.d_src[gi*REG_W +: REG_W]),
        .used    (hif.d_src_used[gi]),
        .entries (ent_q),
        .hit     (d_hit[gi]),
        .stage   (d_stage[gi]),
        .tnew    (d_tnew_m[gi])
      );

      hazard_match #(
        .REG_W(REG_W), .TNEW_W(TNEW_W), .STAGES(STAGES), .FIRST(1), .FS_W(FS_W)
      ) u_match_e (
        .src     (e_src_q[gi*REG_W +: REG_W]),
        .used    (e_used_q[gi]),
        .entries (ent_q),
        .hit     (e_hit[gi]),
        .stage   (e_stage[gi]),
        .tnew    (e_tnew_m[gi])
      );

      assign late[gi] = d_hit[gi] && (d_tnew_m[gi] > hif.d_tuse[gi*TNEW_W +: TNEW_W]);
      assign hif.fwd_d[gi*FS_W +: FS_W] =
        (d_hit[gi] && (d_tnew_m[gi] == '0)) ? d_stage[gi] : FS_W'(FWD_RF);
      assign hif.fwd_e[gi*FS_W +: FS_W] =
        (e_hit[gi] && (e_tnew_m[gi] == '0)) ? e_stage[gi] : FS_W'(FWD_RF);
    end
  endgenerate

  // Stall on a not-yet-ready producer or on HI/LO use while mult/div runs.
  always_comb begin
    md_busy = (md_cnt_q != '0);
    stall   = (|late) || (hif.d_md_use && (md_busy || ent_q[0].md));
    accept  = hif.d_valid && !stall && !hif.clear;
  end

  assign hif.stall   = stall;
  assign hif.md_busy = md_busy;

  // Next state: shift entries with saturating Tnew countdown, capture E
  // operand copies, and run the mult/div busy counter.
  always_comb begin
    ent_d[0] = BUBBLE;
    if (accept) begin
      ent_d[0].dst  = hif.d_dst;
      ent_d[0].tnew = hif.d_tnew;
      ent_d[0].md   = hif.d_md_start;
    end
    for (int k = 1; k < STAGES; k++) begin
      ent_d[k] = ent_q[k-1];
      if (ent_q[k-1].tnew != '0) ent_d[k].tnew = ent_q[k-1].tnew - 1'b1;
    end
    e_src_d  = stall ? '0 : hif.d_src;
    e_used_d = stall ? '0 : hif.d_src_used;
    md_cnt_d = md_cnt_q;
    if (accept && hif.d_md_start) md_cnt_d = MDC_W'(MD_LAT);
    else if (md_cnt_q != '0)      md_cnt_d = md_cnt_q - 1'b1;
  end

  // State registers with asynchronous clear to an empty pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) ent_q[k] <= BUBBLE;
      e_src_q  <= '0;
      e_used_q <= '0;
      md_cnt_q <= '0;
    end else begin
      ent_q    <= ent_d;
      e_src_q  <= e_src_d;
      e_used_q <= e_used_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios followed by random
// decode traffic, checked against a time-indexed model of in-flight instructions.
module tb_hazard_scoreboard;

  localparam int REG_W = 5, TNEW_W = 2, STAGES = 3, RD_PORTS = 2, MD_LAT = 5, FS_W = 2;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(REG_W), .TNEW_W(TNEW_W), .STAGES(STAGES),
                         .RD_PORTS(RD_PORTS), .FS_W(FS_W)) hif ();

  hazard_scoreboard #(.REG_W(REG_W), .TNEW_W(TNEW_W), .STAGES(STAGES),
                      .RD_PORTS(RD_PORTS), .MD_LAT(MD_LAT), .FS_W(FS_W))
    dut (.clk(clk), .reset_n(reset_n), .hif(hif));

  // Model: every instruction accepted into E is recorded against the cycle it
  // entered E; its stage and remaining Tnew follow from elapsed time.
  typedef struct { bit v; int dst; int tnew; bit md; } rec_t;
  rec_t hist [HN];
  int   esrc  [HN][RD_PORTS];
  bit   eused [HN][RD_PORTS];
  int   cyc, base, last_md;
  int   checks = 0, errors = 0;
  bit   exp_stall;

  function automatic rec_t hist_at(input int c);
    rec_t r;
    r = '{0, 0, 0, 0};
    if (c > base) r = hist[c % HN];
    return r;
  endfunction

  function automatic int md_left(input int c);
    if (last_md <= base) return 0;
    return (MD_LAT - (c - last_md) > 0) ? MD_LAT - (c - last_md) : 0;
  endfunction

  // Youngest producer of src among stages first..STAGES at cycle c.
  task automatic find(input int src, input bit used, input int first, input int c,
                      output bit hit, output int stg, output int rem);
    rec_t r;
    hit = 0; stg = 0; rem = 0;
    if (used && src != 0) begin
      for (int s = first; s <= STAGES && !hit; s++) begin
        r = hist_at(c - s + 1);
        if (r.v && r.dst == src) begin
          hit = 1; stg = s;
          rem = (r.tnew - (s - 1) > 0) ? r.tnew - (s - 1) : 0;
        end
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int dst, input int tnew, input int s0,
                       input bit u0, input int t0, input bit mds, input bit mdu, input bit clr);
    hif.d_valid    = v;
    hif.d_dst      = REG_W'(dst);
    hif.d_tnew     = TNEW_W'(tnew);
    hif.d_src      = {REG_W'(0), REG_W'(s0)};
    hif.d_src_used = {1'b0, u0};
    hif.d_tuse     = {TNEW_W'(0), TNEW_W'(t0)};
    hif.d_md_start = mds;
    hif.d_md_use   = mdu;
    hif.clear      = clr;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Let combinational outputs settle, then compare against the model.
  task automatic settle(input string tag);
    bit hit; int stg, rem, src, tuse;
    logic [31:0] obs;
    #2;
    exp_stall = hif.d_md_use && (md_left(cyc) > 0 || hist_at(cyc).md);
    for (int p = 0; p < RD_PORTS; p++) begin
      src  = int'(hif.d_src[p*REG_W +: REG_W]);
      tuse = int'(hif.d_tuse[p*TNEW_W +: TNEW_W]);
      find(src, hif.d_src_used[p], 1, cyc, hit, stg, rem);
      if (hit && rem > tuse) exp_stall = 1;
      obs = 32'(hif.fwd_d[p*FS_W +: FS_W]);
      cmp($sformatf("%s fwd_d[%0d]", tag, p), obs, (hit && rem == 0) ? stg : 0);
      if (cyc > base) find(esrc[cyc % HN][p], eused[cyc % HN][p], 2, cyc, hit, stg, rem);
      else begin hit = 0; stg = 0; rem = 0; end
      obs = 32'(hif.fwd_e[p*FS_W +: FS_W]);
      cmp($sformatf("%s fwd_e[%0d]", tag, p), obs, (hit && rem == 0) ? stg : 0);
    end
    cmp({tag, " stall"}, 32'(hif.stall), 32'(exp_stall));
    cmp({tag, " md_busy"}, 32'(hif.md_busy), (md_left(cyc) > 0) ? 1 : 0);
  endtask

  // Commit the model's view of this cycle and advance one clock.
  task automatic tick();
    bit acc;
    int n;
    acc = hif.d_valid && !exp_stall && !hif.clear;
    n = (cyc + 1) % HN;
    if (acc) hist[n] = '{1, int'(hif.d_dst), int'(hif.d_tnew), hif.d_md_start};
    else     hist[n] = '{0, 0, 0, 0};
    if (acc && hif.d_md_start) last_md = cyc + 1;
    for (int p = 0; p < RD_PORTS; p++) begin
      esrc[n][p]  = exp_stall ? 0 : int'(hif.d_src[p*REG_W +: REG_W]);
      eused[n][p] = exp_stall ? 1'b0 : hif.d_src_used[p];
    end
    $display("cyc %0d: valid=%0b dst=%0d src=%0h stall=%0b fwd_d=%0h fwd_e=%0h md_busy=%0b",
             cyc, hif.d_valid, hif.d_dst, hif.d_src, hif.stall, hif.fwd_d, hif.fwd_e, hif.md_busy);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (4) begin settle("flush"); tick(); end
  endtask

  initial begin
    last_md = -1000;
    nop();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc = 0; base = 0;

    // Reset state
    settle("reset");
    cmp("reset stall", 32'(hif.stall), 0);
    cmp("reset fwd_d", 32'(hif.fwd_d), 0);
    cmp("reset fwd_e", 32'(hif.fwd_e), 0);
    cmp("reset md_busy", 32'(hif.md_busy), 0);
    tick();

    // lw r8 (tnew 2) then consumer of r8 with tuse 1
    drive(1, 8, 2, 0, 0, 0, 0, 0, 0); settle("lw"); tick();
    drive(1, 10, 0, 8, 1, 1, 0, 0, 0); settle("lw use"); cmp("lw stall on", 32'(hif.stall), 1); tick();
    settle("lw use2"); cmp("lw stall off", 32'(hif.stall), 0); tick();
    nop(); settle("lw fwd"); cmp("lw fwd_e W", 32'(hif.fwd_e[FS_W-1:0]), 3); tick();
    flush();

    // ori r9 (tnew 1) then beq on r9 with tuse 0
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0); settle("ori"); tick();
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0); settle("beq"); cmp("beq stall on", 32'(hif.stall), 1); tick();
    settle("beq2"); cmp("beq stall off", 32'(hif.stall), 0);
    cmp("beq fwd_d M", 32'(hif.fwd_d[FS_W-1:0]), 2); tick();
    flush();

    // two writers of r5; the younger must be forwarded
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0); settle("w5a"); tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0); settle("w5b"); tick();
    drive(1, 11, 0, 5, 1, 1, 0, 0, 0); settle("r5"); cmp("r5 no stall", 32'(hif.stall), 0); tick();
    nop(); settle("r5 e"); cmp("r5 fwd_e young", 32'(hif.fwd_e[FS_W-1:0]), 2); tick();
    flush();

    // writes to r0 never create a hazard
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0); settle("w0"); tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0); settle("r0");
    cmp("r0 stall", 32'(hif.stall), 0); cmp("r0 fwd_d", 32'(hif.fwd_d[FS_W-1:0]), 0); tick();
    flush();

    // mult then mflo: exactly MD_LAT stalled cycles
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); settle("mult"); tick();
    drive(1, 2, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MD_LAT; i++) begin
      settle("mflo"); cmp("mflo stall", 32'(hif.stall), 1); cmp("mflo busy", 32'(hif.md_busy), 1); tick();
    end
    settle("mflo go"); cmp("mflo release", 32'(hif.stall), 0); cmp("md idle", 32'(hif.md_busy), 0); tick();
    flush();

    // asynchronous reset in the middle of a load-use stall
    drive(1, 8, 2, 0, 0, 0, 0, 0, 0); settle("lw2"); tick();
    drive(1, 10, 0, 8, 1, 1, 0, 0, 0); settle("lw2 use"); cmp("lw2 stall on", 32'(hif.stall), 1);
    #1 reset_n = 1'b0;
    #1;
    cmp("async rst stall", 32'(hif.stall), 0);
    cmp("async rst md_busy", 32'(hif.md_busy), 0);
    cmp("async rst fwd_d", 32'(hif.fwd_d), 0);
    @(posedge clk); @(posedge clk); cyc += 2;
    #1 reset_n = 1'b1;
    base = cyc; last_md = -1000;
    settle("post rst"); cmp("post rst stall", 32'(hif.stall), 0);
    cmp("post rst fwd_d", 32'(hif.fwd_d), 0); tick();
    nop(); settle("post rst e"); cmp("post rst fwd_e", 32'(hif.fwd_e), 0); tick();

    // random decode traffic with frequent register collisions
    for (int i = 0; i < 500; i++) begin
      hif.d_valid    = ($urandom_range(0, 3) != 0);
      hif.d_dst      = REG_W'($urandom_range(0, 7));
      hif.d_tnew     = TNEW_W'($urandom_range(0, 3));
      hif.d_src      = {REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7))};
      hif.d_src_used = RD_PORTS'($urandom_range(0, 3));
      hif.d_tuse     = {TNEW_W'($urandom_range(0, 3)), TNEW_W'($urandom_range(0, 3))};
      hif.d_md_start = ($urandom_range(0, 15) == 0);
      hif.d_md_use   = hif.d_md_start || ($urandom_range(0, 5) == 0);
      hif.clear      = ($urandom_range(0, 9) == 0);
      settle("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
